// File: rtl/third_section_alu_pkg.sv
// Shared opcode definitions for the execute-stage ALU of the MIPS single-cycle datapath.
package third_section_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SLL = 4'b0011;
  localparam alu_op_t ALU_SRL = 4'b0100;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_NOR = 4'b1100;

endpackage

// File: rtl/third_section_alu_core.sv
// Combinational ALU datapath: (A, B, x) -> next result and its zero flag.
// Shift opcodes are generated only when ALU_SHIFT_EN is defined.
module third_section_alu_core
  import third_section_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          x,
  output logic [WIDTH-1:0] c_next,
  output logic             zero_next
);

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0] shamt;
  // Only the low log2(WIDTH) bits of A set the shift distance.
  assign shamt = A[SHW-1:0];
`endif

  logic lt;
  assign lt = ($signed(A) < $signed(B));

  always_comb begin
    c_next = '0;
    unique case (x)
      ALU_AND: c_next = A & B;
      ALU_OR:  c_next = A | B;
      ALU_ADD: c_next = A + B;
      ALU_SUB: c_next = A - B;
      ALU_SLT: c_next = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR: c_next = ~(A | B);
`ifdef ALU_SHIFT_EN
      ALU_SLL: c_next = B << shamt;
      ALU_SRL: c_next = B >> shamt;
`endif
      default: c_next = '0;
    endcase
  end

  assign zero_next = (c_next == '0);

endmodule

// File: rtl/third_section_alu.sv
// Execute-stage ALU with a one-cycle registered result C and zero flag (drives BEQ).
// Optional SLL/SRL opcodes are enabled by defining ALU_SHIFT_EN.
module third_section_alu
  import third_section_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       x,
  output logic             zero,
  output logic [WIDTH-1:0] C
);

  logic [WIDTH-1:0] c_next;
  logic             zero_next;

  third_section_alu_core #(.WIDTH(WIDTH)) u_core (
    .A         (A),
    .B         (B),
    .x         (alu_op_t'(x)),
    .c_next    (c_next),
    .zero_next (zero_next)
  );

  // Reset value keeps zero consistent with C == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C    <= '0;
      zero <= 1'b1;
    end else begin
      C    <= c_next;
      zero <= zero_next;
    end
  end

endmodule

// File: tb/tb_third_section_alu.sv
// Directed self-checking bench for third_section_alu (shift cases follow ALU_SHIFT_EN).
module tb_third_section_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   x;
  logic         zero;
  logic [W-1:0] c;

  int tests;
  int fails;

  third_section_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .x     (x),
    .zero  (zero),
    .C     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp_c, input logic exp_z);
    tests++;
    assert (c === exp_c) else begin
      fails++;
      $error("FAIL %s: C=%h expected %h", tag, c, exp_c);
    end
    tests++;
    assert (zero === exp_z) else begin
      fails++;
      $error("FAIL %s: zero=%b expected %b", tag, zero, exp_z);
    end
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] xv);
    @(negedge clk);
    a = av;
    b = bv;
    x = xv;
  endtask

  task automatic step(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [3:0] xv, input logic [W-1:0] exp_c, input logic exp_z);
    drive(av, bv, xv);
    @(posedge clk);
    #1;
    check(tag, exp_c, exp_z);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    x = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    step("and", 32'd12, 32'd15, 4'b0000, 32'd12, 1'b0);

    // OR applied: output must still hold AND result until the next edge.
    drive(32'd17, 32'd20, 4'b0001);
    #1;
    check("or_hold", 32'd12, 1'b0);
    @(posedge clk);
    #1;
    check("or", 32'd21, 1'b0);

    step("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'h0, 1'b1);
    step("add", 32'd100, 32'd23, 4'b0010, 32'd123, 1'b0);
    step("sub_eq", 32'd5, 32'd5, 4'b0110, 32'h0, 1'b1);
    step("sub_neg", 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0);
    step("slt_neg", 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);
    step("slt_pos", 32'd1, 32'hFFFF_FFFF, 4'b0111, 32'd0, 1'b1);
    step("slt_bound", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 32'd1, 1'b0);
    step("slt_unsgn", 32'd2, 32'd9, 4'b0111, 32'd1, 1'b0);
    step("nor_zero", 32'h0, 32'h0, 4'b1100, 32'hFFFF_FFFF, 1'b0);
    step("nor_mix", 32'h0F0F_0000, 32'h0000_00FF, 4'b1100, 32'hF0F0_FF00, 1'b0);
    step("and_mix", 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0000, 32'h00F0_1200, 1'b0);

    // Async reset between edges discards the pending ADD result.
    step("add_pre_rst", 32'd7, 32'd8, 4'b0010, 32'd15, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_hold", 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst", 32'd15, 1'b0);

`ifdef ALU_SHIFT_EN
    step("sll", 32'd4, 32'd1, 4'b0011, 32'd16, 1'b0);
    step("srl", 32'd4, 32'h100, 4'b0100, 32'h10, 1'b0);
    step("sll_amt", 32'hFFFF_FFE1, 32'd1, 4'b0011, 32'd2, 1'b0);
    step("srl_amt", 32'h0000_0024, 32'h8000_0000, 4'b0100, 32'h0800_0000, 1'b0);
`else
    step("sll_off", 32'd4, 32'd1, 4'b0011, 32'h0, 1'b1);
    step("srl_off", 32'd4, 32'h100, 4'b0100, 32'h0, 1'b1);
`endif

    step("add_again", 32'd1, 32'd1, 4'b0010, 32'd2, 1'b0);
    step("illegal_f", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    step("illegal_5", 32'h0000_00FF, 32'h0000_00F0, 4'b0101, 32'h0, 1'b1);
    step("illegal_8", 32'h1234_5678, 32'h1, 4'b1000, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
